// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter that merges N_CH bus masters onto one single-ported memory
// with a fixed number of wait states per access.
module cpu_bus_arbiter #(
   parameter int N_CH        = 2,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic [N_CH-1:0]            iReadEnable,
   input  logic [N_CH-1:0]            iWriteEnable,
   input  logic [N_CH*(DATA_W/8)-1:0] iByteEnable,
   input  logic [N_CH*ADDR_W-1:0]     iAddress,
   input  logic [N_CH*DATA_W-1:0]     iWriteData,
   output logic [N_CH-1:0]            oAck,
   output logic [DATA_W-1:0]          oReadData,
   output logic                       oMemReadEnable,
   output logic                       oMemWriteEnable,
   output logic [DATA_W/8-1:0]        oMemByteEnable,
   output logic [ADDR_W-1:0]          oMemAddress,
   output logic [DATA_W-1:0]          oMemWriteData,
   input  logic [DATA_W-1:0]          iMemReadData,
   output logic [5:0]                 mControlState
);

   localparam int          BE_W  = DATA_W / 8;
   localparam logic [4:0]  NCH5  = 5'(N_CH);
   localparam logic [3:0]  LAST4 = 4'(N_CH - 1);
   localparam logic [3:0]  WS4   = 4'(WAIT_STATES);

   // state  | meaning
   // IDLE   | arbitrate among current requests, memory strobes low
   // ACCESS | drive memory from latched request, count down wait states
   // DONE   | ack pulse to the served channel, advance round-robin pointer
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_ptr;
   logic [3:0]  r_grant;
   logic [3:0]  r_cnt;
   logic        r_is_write;

   logic [N_CH-1:0]   w_req;
   logic [N_CH-1:0]   w_req_rot;
   logic              w_any;
   logic [4:0]        w_off;
   logic [4:0]        w_sum;
   logic [3:0]        w_pick;
   logic              w_sel_wr;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [BE_W-1:0]   w_sel_be;
   logic [N_CH-1:0]   w_grant_oh;
   logic [3:0]        w_ptr_next;

   assign w_req     = iReadEnable | iWriteEnable;
   assign w_any     = |w_req;
   assign w_req_rot = N_CH'({w_req, w_req} >> r_ptr);

   // Lowest set bit of the rotated request vector is the offset from the pointer.
   always_comb begin
      w_off = 5'd0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_req_rot[i]) w_off = 5'(i);
      end
      w_sum = {1'b0, r_ptr} + w_off;
      if (w_sum >= NCH5) w_sum = w_sum - NCH5;
      w_pick = w_sum[3:0];
   end

   always_comb begin
      w_sel_wr    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
      w_grant_oh  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_pick == 4'(c)) begin
            w_sel_wr    = iWriteEnable[c];
            w_sel_addr  = iAddress[c*ADDR_W +: ADDR_W];
            w_sel_wdata = iWriteData[c*DATA_W +: DATA_W];
            w_sel_be    = iByteEnable[c*BE_W +: BE_W];
         end
         w_grant_oh[c] = (r_grant == 4'(c));
      end
   end

   assign w_ptr_next    = (r_grant == LAST4) ? 4'd0 : r_grant + 4'd1;
   assign mControlState = {r_state, r_grant};

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state         <= S_IDLE;
         r_ptr           <= 4'd0;
         r_grant         <= 4'd0;
         r_cnt           <= 4'd0;
         r_is_write      <= 1'b0;
         oAck            <= '0;
         oReadData       <= '0;
         oMemReadEnable  <= 1'b0;
         oMemWriteEnable <= 1'b0;
         oMemByteEnable  <= '0;
         oMemAddress     <= '0;
         oMemWriteData   <= '0;
      end else begin
         oAck <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state         <= S_ACCESS;
                  r_grant         <= w_pick;
                  r_cnt           <= WS4;
                  r_is_write      <= w_sel_wr;
                  oMemAddress     <= w_sel_addr;
                  oMemWriteData   <= w_sel_wdata;
                  oMemByteEnable  <= w_sel_be;
                  oMemReadEnable  <= ~w_sel_wr;
                  oMemWriteEnable <= w_sel_wr & (WS4 == 4'd0);
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  if (!r_is_write) oReadData <= iMemReadData;
                  oAck            <= w_grant_oh;
                  oMemReadEnable  <= 1'b0;
                  oMemWriteEnable <= 1'b0;
                  oMemAddress     <= '0;
                  oMemWriteData   <= '0;
                  oMemByteEnable  <= '0;
                  r_state         <= S_DONE;
               end else begin
                  r_cnt           <= r_cnt - 4'd1;
                  // The single write pulse lands in the last access cycle.
                  oMemWriteEnable <= r_is_write & (r_cnt == 4'd1);
               end
            end
            S_DONE: begin
               r_ptr   <= w_ptr_next;
               r_grant <= 4'd0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
